// File: rtl/bcp_checker_array.sv
// rtl/bcp_checker_array.sv - multi-slot BCP clause checker with hold-until-ack result
//
// Purpose: holds CLAUSE_NUM clause slots (type/mask/valid) and evaluates them all
// against a snapshot of free/assignment, reporting a conflict or one implication.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   clear_all                invalidate every slot (IDLE only, beats load_en)
//   load_en/load_idx         write one slot (IDLE only)
//   load_type/load_mask      literal polarity / literal present
//   start                    snapshot free/assignment and evaluate (IDLE only)
//   free/assignment          current variable state
//   ack                      consume the held result (RESULT only)
//   busy                     FSM not in IDLE
//   result_valid             result held on outputs
//   conflict/unit_found      outcome flags
//   imp_var/imp_value        implied variable and its value
//   imp_clause               source slot of the conflict or unit
//   unit_count               number of unit slots in this evaluation
module bcp_checker_array #(
   parameter int VAR_NUM        = 7,
   parameter int VAR_NUM_LOG    = 3,
   parameter int CLAUSE_NUM     = 4,
   parameter int CLAUSE_NUM_LOG = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear_all,
   input  logic                      load_en,
   input  logic [CLAUSE_NUM_LOG-1:0] load_idx,
   input  logic [VAR_NUM-1:0]        load_type,
   input  logic [VAR_NUM-1:0]        load_mask,
   input  logic                      start,
   input  logic [VAR_NUM-1:0]        free,
   input  logic [VAR_NUM-1:0]        assignment,
   input  logic                      ack,
   output logic                      busy,
   output logic                      result_valid,
   output logic                      conflict,
   output logic                      unit_found,
   output logic [VAR_NUM_LOG-1:0]    imp_var,
   output logic                      imp_value,
   output logic [CLAUSE_NUM_LOG-1:0] imp_clause,
   output logic [CLAUSE_NUM_LOG:0]   unit_count
);

   localparam int NF_W = VAR_NUM_LOG + 1;
   localparam int UC_W = CLAUSE_NUM_LOG + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EVAL   = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [CLAUSE_NUM-1:0][VAR_NUM-1:0] type_q, type_d;
   logic [CLAUSE_NUM-1:0][VAR_NUM-1:0] mask_q, mask_d;
   logic [CLAUSE_NUM-1:0]              valid_q, valid_d;
   logic [VAR_NUM-1:0]                 snap_free_q, snap_free_d;
   logic [VAR_NUM-1:0]                 snap_asg_q, snap_asg_d;

   logic                      result_valid_q, result_valid_d;
   logic                      conflict_q, conflict_d;
   logic                      unit_found_q, unit_found_d;
   logic [VAR_NUM_LOG-1:0]    imp_var_q, imp_var_d;
   logic                      imp_value_q, imp_value_d;
   logic [CLAUSE_NUM_LOG-1:0] imp_clause_q, imp_clause_d;
   logic [UC_W-1:0]           unit_count_q, unit_count_d;

   // Per-slot evaluation against the snapshot registers
   logic [CLAUSE_NUM-1:0]                  slot_sat;
   logic [CLAUSE_NUM-1:0][NF_W-1:0]        slot_nfree;
   logic [CLAUSE_NUM-1:0][VAR_NUM_LOG-1:0] slot_free_idx;
   logic [CLAUSE_NUM-1:0]                  slot_unit;
   logic [CLAUSE_NUM-1:0]                  slot_confl;

   always_comb begin
      slot_sat      = '0;
      slot_nfree    = '0;
      slot_free_idx = '0;
      slot_unit     = '0;
      slot_confl    = '0;
      for (int c = 0; c < CLAUSE_NUM; c++) begin
         for (int i = 0; i < VAR_NUM; i++) begin
            if (mask_q[c][i] && !snap_free_q[i] && (snap_asg_q[i] == type_q[c][i])) begin
               slot_sat[c] = 1'b1;
            end
            // The free-literal index is only meaningful when exactly one is free
            if (mask_q[c][i] && snap_free_q[i]) begin
               slot_nfree[c]    = slot_nfree[c] + NF_W'(1);
               slot_free_idx[c] = VAR_NUM_LOG'(i);
            end
         end
         slot_unit[c]  = valid_q[c] && !slot_sat[c] && (slot_nfree[c] == NF_W'(1));
         slot_confl[c] = valid_q[c] && !slot_sat[c] && (slot_nfree[c] == NF_W'(0));
      end
   end

   // Lowest-index selection and unit count across slots
   logic                      any_confl, any_unit;
   logic [CLAUSE_NUM_LOG-1:0] first_confl, first_unit;
   logic [UC_W-1:0]           ucount;

   always_comb begin
      any_confl   = |slot_confl;
      any_unit    = |slot_unit;
      first_confl = '0;
      first_unit  = '0;
      ucount      = '0;
      for (int c = CLAUSE_NUM - 1; c >= 0; c--) begin
         if (slot_confl[c]) first_confl = CLAUSE_NUM_LOG'(c);
         if (slot_unit[c])  first_unit  = CLAUSE_NUM_LOG'(c);
         ucount = ucount + UC_W'(slot_unit[c]);
      end
   end

   always_comb begin
      state_d        = state_q;
      type_d         = type_q;
      mask_d         = mask_q;
      valid_d        = valid_q;
      snap_free_d    = snap_free_q;
      snap_asg_d     = snap_asg_q;
      result_valid_d = result_valid_q;
      conflict_d     = conflict_q;
      unit_found_d   = unit_found_q;
      imp_var_d      = imp_var_q;
      imp_value_d    = imp_value_q;
      imp_clause_d   = imp_clause_q;
      unit_count_d   = unit_count_q;

      case (state_q)
         ST_IDLE: begin
            if (clear_all) begin
               valid_d = '0;
            end else if (load_en && ({1'b0, load_idx} < UC_W'(CLAUSE_NUM))) begin
               type_d[load_idx]  = load_type;
               mask_d[load_idx]  = load_mask;
               valid_d[load_idx] = |load_mask;
            end
            if (start) begin
               snap_free_d = free;
               snap_asg_d  = assignment;
               state_d     = ST_EVAL;
            end
         end
         ST_EVAL: begin
            result_valid_d = 1'b1;
            conflict_d     = any_confl;
            unit_found_d   = !any_confl && any_unit;
            unit_count_d   = ucount;
            imp_var_d      = '0;
            imp_value_d    = 1'b0;
            imp_clause_d   = '0;
            if (any_confl) begin
               imp_clause_d = first_confl;
            end else if (any_unit) begin
               imp_clause_d = first_unit;
               imp_var_d    = slot_free_idx[first_unit];
               imp_value_d  = type_q[first_unit][slot_free_idx[first_unit]];
            end
            state_d = ST_RESULT;
         end
         ST_RESULT: begin
            if (ack) begin
               result_valid_d = 1'b0;
               conflict_d     = 1'b0;
               unit_found_d   = 1'b0;
               imp_var_d      = '0;
               imp_value_d    = 1'b0;
               imp_clause_d   = '0;
               unit_count_d   = '0;
               state_d        = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         type_q         <= '0;
         mask_q         <= '0;
         valid_q        <= '0;
         snap_free_q    <= '0;
         snap_asg_q     <= '0;
         result_valid_q <= 1'b0;
         conflict_q     <= 1'b0;
         unit_found_q   <= 1'b0;
         imp_var_q      <= '0;
         imp_value_q    <= 1'b0;
         imp_clause_q   <= '0;
         unit_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         type_q         <= type_d;
         mask_q         <= mask_d;
         valid_q        <= valid_d;
         snap_free_q    <= snap_free_d;
         snap_asg_q     <= snap_asg_d;
         result_valid_q <= result_valid_d;
         conflict_q     <= conflict_d;
         unit_found_q   <= unit_found_d;
         imp_var_q      <= imp_var_d;
         imp_value_q    <= imp_value_d;
         imp_clause_q   <= imp_clause_d;
         unit_count_q   <= unit_count_d;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign result_valid = result_valid_q;
   assign conflict     = conflict_q;
   assign unit_found   = unit_found_q;
   assign imp_var      = imp_var_q;
   assign imp_value    = imp_value_q;
   assign imp_clause   = imp_clause_q;
   assign unit_count   = unit_count_q;

endmodule

// File: tb/tb_bcp_checker_array.sv
// tb/tb_bcp_checker_array.sv - self-checking bench for bcp_checker_array
module tb_bcp_checker_array;

   localparam int VN  = 7;
   localparam int VNL = 3;
   localparam int CN  = 4;
   localparam int CNL = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           clear_all;
   logic           load_en;
   logic [CNL-1:0] load_idx;
   logic [VN-1:0]  load_type;
   logic [VN-1:0]  load_mask;
   logic           start;
   logic [VN-1:0]  free;
   logic [VN-1:0]  assignment;
   logic           ack;
   logic           busy;
   logic           result_valid;
   logic           conflict;
   logic           unit_found;
   logic [VNL-1:0] imp_var;
   logic           imp_value;
   logic [CNL-1:0] imp_clause;
   logic [CNL:0]   unit_count;

   bcp_checker_array #(
      .VAR_NUM(VN), .VAR_NUM_LOG(VNL), .CLAUSE_NUM(CN), .CLAUSE_NUM_LOG(CNL)
   ) dut (
      .clk(clk), .rst(rst), .clear_all(clear_all), .load_en(load_en),
      .load_idx(load_idx), .load_type(load_type), .load_mask(load_mask),
      .start(start), .free(free), .assignment(assignment), .ack(ack),
      .busy(busy), .result_valid(result_valid), .conflict(conflict),
      .unit_found(unit_found), .imp_var(imp_var), .imp_value(imp_value),
      .imp_clause(imp_clause), .unit_count(unit_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: clause table and expected result
   logic [VN-1:0] m_type  [CN];
   logic [VN-1:0] m_mask  [CN];
   bit            m_valid [CN];
   bit e_conf, e_unit, e_val;
   int e_var, e_clause, e_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int c = 0; c < CN; c++) begin
         m_type[c] = '0; m_mask[c] = '0; m_valid[c] = 0;
      end
   endtask

   task automatic model_eval(input logic [VN-1:0] f, input logic [VN-1:0] a);
      int fc, fu;
      bit sat;
      int nf;
      logic [VN-1:0] fl;
      fc = -1; fu = -1;
      e_conf = 0; e_unit = 0; e_val = 0; e_var = 0; e_clause = 0; e_cnt = 0;
      for (int c = 0; c < CN; c++) begin
         if (m_valid[c]) begin
            sat = |(m_mask[c] & ~f & ~(a ^ m_type[c]));
            nf  = $countones(m_mask[c] & f);
            if (!sat && nf == 0 && fc < 0) fc = c;
            if (!sat && nf == 1) begin
               e_cnt++;
               if (fu < 0) fu = c;
            end
         end
      end
      if (fc >= 0) begin
         e_conf = 1; e_clause = fc;
      end else if (fu >= 0) begin
         e_unit = 1; e_clause = fu;
         fl = m_mask[fu] & f;
         for (int i = 0; i < VN; i++) if (fl[i]) e_var = i;
         e_val = m_type[fu][e_var];
      end
   endtask

   task automatic do_load(input int idx, input logic [VN-1:0] t, input logic [VN-1:0] m);
      load_en = 1; load_idx = CNL'(idx); load_type = t; load_mask = m;
      tick();
      load_en = 0;
      m_type[idx] = t; m_mask[idx] = m; m_valid[idx] = (m != 0);
   endtask

   task automatic do_clear();
      clear_all = 1;
      tick();
      clear_all = 0;
      for (int c = 0; c < CN; c++) m_valid[c] = 0;
   endtask

   task automatic check_result(input string tag);
      check({tag, ".valid"}, result_valid, 1);
      check({tag, ".conflict"}, conflict, e_conf);
      check({tag, ".unit"}, unit_found, e_unit);
      check({tag, ".var"}, imp_var, e_var);
      check({tag, ".value"}, imp_value, e_val);
      check({tag, ".clause"}, imp_clause, e_clause);
      check({tag, ".count"}, unit_count, e_cnt);
   endtask

   // Start, check latency, leave the result held (no ack)
   task automatic start_eval(input string tag, input logic [VN-1:0] f, input logic [VN-1:0] a);
      free = f; assignment = a; start = 1;
      model_eval(f, a);
      tick();
      start = 0;
      check({tag, ".busy_eval"}, busy, 1);
      check({tag, ".rv_early"}, result_valid, 0);
      tick();
      check_result(tag);
   endtask

   task automatic do_ack(input string tag);
      ack = 1;
      tick();
      ack = 0;
      check({tag, ".rv_after_ack"}, result_valid, 0);
      check({tag, ".busy_after_ack"}, busy, 0);
   endtask

   task automatic eval_full(input string tag, input logic [VN-1:0] f, input logic [VN-1:0] a);
      start_eval(tag, f, a);
      do_ack(tag);
   endtask

   initial begin
      rst = 1; clear_all = 0; load_en = 0; load_idx = '0; load_type = '0;
      load_mask = '0; start = 0; free = '0; assignment = '0; ack = 0;
      model_reset();
      tick(); tick();
      check("reset.busy", busy, 0);
      check("reset.rv", result_valid, 0);
      check("reset.conflict", conflict, 0);
      check("reset.unit", unit_found, 0);
      check("reset.count", unit_count, 0);
      rst = 0;
      tick();

      // Empty table
      eval_full("empty", 7'b1010101, 7'b0011001);

      // Unit and conflict on slot0
      do_load(0, 7'b0000011, 7'b0000111);
      eval_full("unit", 7'b1111100, 7'b0000000);
      check("unit.const_var", e_var, 2);
      eval_full("confl", 7'b1111000, 7'b0000100);
      check("confl.const", e_conf, 1);

      // Priority: slot1 conflicting, slot3 unit on x5
      do_clear();
      do_load(1, 7'b0000001, 7'b0000001);
      do_load(3, 7'b0100001, 7'b0100001);
      eval_full("prio_confl", 7'b0100000, 7'b0000000);
      do_load(1, 7'b0000000, 7'b0000001);
      eval_full("prio_unit", 7'b0100000, 7'b0000000);

      // Load with zero mask stays invalid; satisfied-only table
      do_clear();
      do_load(2, 7'b1111111, 7'b0000000);
      eval_full("mask0", 7'b0000000, 7'b0000000);
      do_load(0, 7'b0000001, 7'b0000011);
      eval_full("sat", 7'b0000010, 7'b0000001);

      // Handshake: outputs held while free toggles, start and load pulse
      do_load(0, 7'b0000011, 7'b0000111);
      start_eval("hold", 7'b1111100, 7'b0000000);
      for (int k = 0; k < 3; k++) begin
         free = VN'($urandom); start = 1; load_en = 1; load_idx = 0;
         load_type = 7'b1111111; load_mask = 7'b1111111;
         tick();
         check_result("hold_cyc");
         check("hold.busy", busy, 1);
      end
      start = 0; load_en = 0;
      do_ack("hold");
      eval_full("hold_slot", 7'b1111100, 7'b0000000);

      // Reset while in EVAL
      free = 7'b1111100; assignment = '0; start = 1;
      tick();
      start = 0;
      rst = 1;
      tick();
      rst = 0;
      check("rst_eval.busy", busy, 0);
      check("rst_eval.rv", result_valid, 0);
      model_reset();
      eval_full("after_rst", 7'b1111100, 7'b0000000);
      check("after_rst.no_unit", e_unit, 0);

      // Randomized table updates and evaluations
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) do_clear();
         for (int l = 0; l < $urandom_range(1, 2); l++) begin
            do_load($urandom_range(0, CN - 1), VN'($urandom),
                    ($urandom_range(0, 7) == 0) ? '0 : VN'($urandom));
         end
         eval_full("rand", VN'($urandom) & VN'($urandom), VN'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
